// File: rtl/router_pkt_pkg.sv
// Shared router packet definitions: widths, header layout, decapsulator states.
package router_pkt_pkg;

  localparam int unsigned DATA_WIDTH        = 1024;
  localparam int unsigned AURORA_DATA_WIDTH = 64;
  localparam int unsigned HEADER_WIDTH      = 9;
  localparam int unsigned PAYLOAD_WIDTH     = AURORA_DATA_WIDTH - HEADER_WIDTH;
  localparam int unsigned NUMBER_BEATS      = 19;
  localparam int unsigned LAST_BEAT_BITS    = DATA_WIDTH - (NUMBER_BEATS - 1) * PAYLOAD_WIDTH;

  // Bits of the last beat's payload field that carry no data and must be zero.
  localparam int unsigned PAD_WIDTH         = PAYLOAD_WIDTH - LAST_BEAT_BITS;
  // Payload collected from the full beats ahead of the last one.
  localparam int unsigned ASM_WIDTH         = (NUMBER_BEATS - 1) * PAYLOAD_WIDTH;
  localparam int unsigned BEAT_IDX_WIDTH    = $clog2(NUMBER_BEATS);

  // Header field offsets within the 9-bit header.
  localparam int unsigned TTL_LSB           = 0;
  localparam int unsigned TTL_WIDTH         = 2;
  localparam int unsigned PKT_NUM_LSB       = 2;
  localparam int unsigned PKT_NUM_WIDTH     = 5;
  localparam int unsigned ROUTER_ID_LSB     = 7;
  localparam int unsigned ROUTER_ID_WIDTH   = 2;

  typedef struct packed {
    logic [ROUTER_ID_WIDTH-1:0] router_id;
    logic [PKT_NUM_WIDTH-1:0]   pkt_num;
    logic [TTL_WIDTH-1:0]       ttl;
  } pkt_header_t;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } decap_state_t;

  // Payload field of an Aurora beat (everything above the header).
  function automatic logic [PAYLOAD_WIDTH-1:0] beat_payload(
    input logic [AURORA_DATA_WIDTH-1:0] beat
  );
    return beat[AURORA_DATA_WIDTH-1:HEADER_WIDTH];
  endfunction

endpackage

// File: rtl/decap_timeout_cnt.sv
// Loadable/clearable gap counter with a terminal-count pulse on the LIMIT-th increment.
module decap_timeout_cnt #(
  parameter int unsigned LIMIT = 256,
  localparam int unsigned CNT_WIDTH = $clog2(LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 inc,
  output logic                 expire_c
);

  logic [CNT_WIDTH-1:0] count;

  // Terminal count: this increment would bring the counter to LIMIT.
  assign expire_c = inc && !clear && !load && (count == CNT_WIDTH'(LIMIT - 1));

  // Counter register; restarts from zero once it expires.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || expire_c) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/decap_packet.sv
// Strips per-beat headers from 19 Aurora beats and rebuilds one 1024-bit DFX word.
module decap_packet
  import router_pkt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
  input  logic                         data_recv_valid,
  output logic [DATA_WIDTH-1:0]        data_dfx_recv,
  output logic [HEADER_WIDTH-1:0]      header_pkt_recv,
  output logic                         decap_valid,
  output logic                         decap_error,
  output logic                         decap_busy
);

  localparam int unsigned TO_CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  decap_state_t              state;
  logic [BEAT_IDX_WIDTH-1:0] idx;
  pkt_header_t               hdr_q;
  logic [ASM_WIDTH-1:0]      asm_q;

  pkt_header_t               beat_hdr_c;
  logic [PAYLOAD_WIDTH-1:0]  payload_c;
  logic                      hdr_ok_c;
  logic                      pad_ok_c;
  logic                      last_c;
  logic                      gap_c;
  logic                      timeout_c;

  // Beat decode shared by every state.
  assign beat_hdr_c = pkt_header_t'(data_recv[HEADER_WIDTH-1:0]);
  assign payload_c  = beat_payload(data_recv);
  assign hdr_ok_c   = (beat_hdr_c == hdr_q);
  assign pad_ok_c   = (payload_c[PAYLOAD_WIDTH-1:LAST_BEAT_BITS] == PAD_WIDTH'(0));
  assign last_c     = (idx == BEAT_IDX_WIDTH'(NUMBER_BEATS - 1));
  assign gap_c      = (state == COLLECT) && !data_recv_valid;

  // Idle-gap watchdog inside a packet; held clear outside COLLECT and on every beat.
  decap_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear      (!gap_c),
    .load       (1'b0),
    .load_value (TO_CNT_WIDTH'(0)),
    .inc        (gap_c),
    .expire_c   (timeout_c)
  );

  // Collection FSM: beats shift in from the top so beat 0 ends up in the low bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      hdr_q           <= '0;
      asm_q           <= '0;
      data_dfx_recv   <= '0;
      header_pkt_recv <= '0;
      decap_valid     <= 1'b0;
      decap_error     <= 1'b0;
      decap_busy      <= 1'b0;
    end else begin
      decap_valid <= 1'b0;
      decap_error <= 1'b0;
      case (state)
        IDLE: begin
          if (data_recv_valid) begin
            hdr_q      <= beat_hdr_c;
            asm_q      <= {payload_c, asm_q[ASM_WIDTH-1:PAYLOAD_WIDTH]};
            idx        <= BEAT_IDX_WIDTH'(1);
            state      <= COLLECT;
            decap_busy <= 1'b1;
          end
        end
        COLLECT: begin
          if (data_recv_valid) begin
            if (!hdr_ok_c || (last_c && !pad_ok_c)) begin
              decap_error <= 1'b1;
              idx         <= '0;
              state       <= IDLE;
              decap_busy  <= 1'b0;
            end else if (last_c) begin
              data_dfx_recv   <= {data_recv[HEADER_WIDTH +: LAST_BEAT_BITS], asm_q};
              header_pkt_recv <= hdr_q;
              decap_valid     <= 1'b1;
              idx             <= '0;
              state           <= IDLE;
              decap_busy      <= 1'b0;
            end else begin
              asm_q <= {payload_c, asm_q[ASM_WIDTH-1:PAYLOAD_WIDTH]};
              idx   <= idx + 1'b1;
            end
          end else if (timeout_c) begin
            decap_error <= 1'b1;
            idx         <= '0;
            state       <= IDLE;
            decap_busy  <= 1'b0;
          end
        end
        default: begin
          idx        <= '0;
          state      <= IDLE;
          decap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decap_packet.sv
// Scoreboard bench for decap_packet: packets built here, expected words queued, DUT output popped and compared.
module tb_decap_packet;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   data_recv = '0;
  logic          data_recv_valid = 1'b0;
  logic [1023:0] data_dfx_recv;
  logic [8:0]    header_pkt_recv;
  logic          decap_valid;
  logic          decap_error;
  logic          decap_busy;

  decap_packet dut (
    .clk             (clk),
    .rst             (rst),
    .data_recv       (data_recv),
    .data_recv_valid (data_recv_valid),
    .data_dfx_recv   (data_dfx_recv),
    .header_pkt_recv (header_pkt_recv),
    .decap_valid     (decap_valid),
    .decap_error     (decap_error),
    .decap_busy      (decap_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] data;
    logic [8:0]    hdr;
    int            cyc;
  } rx_t;

  rx_t           exp_q[$];
  rx_t           rx_q[$];
  int            err_q[$];
  int            cyc = 0;
  int            last_edge = 0;
  int            overlap = 0;
  int            checks = 0;
  int            failures = 0;
  logic [63:0]   beats[19];
  logic [1023:0] ref_data;
  logic [8:0]    cur_hdr;
  logic [1023:0] last_data = '0;
  logic [8:0]    last_hdr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect completions and error pulses with the edge count they followed.
  always @(negedge clk) begin
    if (!rst) begin
      if (decap_valid) rx_q.push_back('{data_dfx_recv, header_pkt_recv, cyc});
      if (decap_error) err_q.push_back(cyc);
      if (decap_valid && decap_error) overlap++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // Build a packet; patterned payload is {55{k[0]}} ^ k, else random with zero pad.
  task automatic build_packet(input logic [8:0] hdr, input bit patterned);
    logic [54:0] p;
    logic [4:0]  kb;
    cur_hdr  = hdr;
    ref_data = '0;
    for (int k = 0; k < 19; k++) begin
      kb = 5'(k);
      if (patterned) p = {55{kb[0]}} ^ 55'(k);
      else p = 55'({$urandom, $urandom});
      if (k == 18) p[54:34] = '0;
      beats[k] = {p, hdr};
      if (k < 18) ref_data[k*55 +: 55] = p;
      else ref_data[1023:990] = p[33:0];
    end
  endtask

  task automatic drive_beat(input logic [63:0] b);
    @(negedge clk);
    data_recv       = b;
    data_recv_valid = 1'b1;
    last_edge       = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_recv_valid = 1'b0;
      data_recv       = {$urandom, $urandom};
    end
  endtask

  // Send beats 0..n-1 with optional gaps of gap_len cycles after beats g1 and g2.
  task automatic send_beats(input int n, input int g1, input int g2, input int gap_len);
    for (int k = 0; k < n; k++) begin
      drive_beat(beats[k]);
      if (k == g1 || k == g2) idle(gap_len);
    end
  endtask

  task automatic push_expected();
    exp_q.push_back('{ref_data, cur_hdr, last_edge});
  endtask

  function automatic int first_diff(input logic [1023:0] a, input logic [1023:0] b);
    logic [1023:0] d;
    d = a ^ b;
    for (int i = 0; i < 1024; i++) if (d[i] !== 1'b0) return i;
    return -1;
  endfunction

  task automatic pop_compare(input string name);
    rx_t e, r;
    int  waited = 0;
    while (rx_q.size() == 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (rx_q.size() == 0) begin
      failures++;
      $display("FAIL %s no decap_valid within 60 cycles (expected after edge %0d)", name, last_edge);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected decap_valid at edge %0d", name, rx_q[0].cyc);
      void'(rx_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    r = rx_q.pop_front();
    checks++;
    if (r.data !== e.data) begin
      failures++;
      $display("FAIL %s data first differing bit %0d got_lo=%h want_lo=%h", name,
               first_diff(r.data, e.data), r.data[127:0], e.data[127:0]);
    end
    checks++;
    if (r.hdr !== e.hdr) begin
      failures++;
      $display("FAIL %s header got=%h want=%h", name, r.hdr, e.hdr);
    end
    checks++;
    if (r.cyc !== e.cyc) begin
      failures++;
      $display("FAIL %s latency valid after edge %0d want %0d", name, r.cyc, e.cyc);
    end
    last_data = e.data;
    last_hdr  = e.hdr;
  endtask

  task automatic expect_abort(input string name, input int want_cyc);
    int c;
    checks++;
    if (err_q.size() !== 1) begin
      failures++;
      $display("FAIL %s error pulses got=%0d want=1", name, err_q.size());
    end else begin
      c = err_q.pop_front();
      checks++;
      if (c !== want_cyc) begin
        failures++;
        $display("FAIL %s error after edge %0d want %0d", name, c, want_cyc);
      end
    end
    err_q.delete();
    checks++;
    if (rx_q.size() !== 0) begin
      failures++;
      $display("FAIL %s spurious decap_valid count=%0d", name, rx_q.size());
    end
    rx_q.delete();
    checks++;
    if (data_dfx_recv !== last_data || header_pkt_recv !== last_hdr) begin
      failures++;
      $display("FAIL %s outputs changed hdr got=%h want=%h data_lo got=%h want=%h", name,
               header_pkt_recv, last_hdr, data_dfx_recv[63:0], last_data[63:0]);
    end
    checks++;
    if (decap_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy got=%b want=0", name, decap_busy);
    end
  endtask

  task automatic expect_no_errors(input string name);
    checks++;
    if (err_q.size() !== 0) begin
      failures++;
      $display("FAIL %s decap_error pulses got=%0d want=0", name, err_q.size());
    end
    err_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_recv_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (data_dfx_recv !== '0 || header_pkt_recv !== '0) begin
      failures++;
      $display("FAIL reset data/header got hdr=%h data_lo=%h want 0", header_pkt_recv, data_dfx_recv[63:0]);
    end
    checks++;
    if (decap_valid !== 1'b0 || decap_error !== 1'b0 || decap_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset flags got v=%b e=%b b=%b want 0", decap_valid, decap_error, decap_busy);
    end
  endtask

  task automatic test_single();
    build_packet(9'h0A5, 1'b1);
    send_beats(19, -1, -1, 0);
    push_expected();
    idle(1);
    pop_compare("single");
    idle(2);
    expect_no_errors("single");
    checks++;
    if (decap_busy !== 1'b0) begin
      failures++;
      $display("FAIL single busy after packet got=%b want=0", decap_busy);
    end
  endtask

  task automatic test_gapped();
    build_packet(9'h0A5, 1'b1);
    drive_beat(beats[0]);
    idle(1);
    checks++;
    if (decap_busy !== 1'b1) begin
      failures++;
      $display("FAIL gapped busy in collect got=%b want=1", decap_busy);
    end
    for (int k = 1; k < 19; k++) begin
      drive_beat(beats[k]);
      if (k == 4 || k == 12) idle(3);
    end
    push_expected();
    idle(1);
    pop_compare("gapped");
    idle(2);
    expect_no_errors("gapped");
  endtask

  task automatic test_back_to_back();
    build_packet(9'h011, 1'b0);
    send_beats(19, -1, -1, 0);
    push_expected();
    build_packet(9'h012, 1'b0);
    send_beats(19, -1, -1, 0);
    push_expected();
    idle(1);
    pop_compare("b2b_first");
    pop_compare("b2b_second");
    idle(2);
    expect_no_errors("b2b");
  endtask

  task automatic test_header_corrupt();
    build_packet(9'h0A5, 1'b1);
    beats[7][8:0] = 9'h0A4;
    send_beats(8, -1, -1, 0);
    idle(4);
    expect_abort("hdr_corrupt", last_edge);
    build_packet(9'h0C3, 1'b0);
    send_beats(19, -1, -1, 0);
    push_expected();
    idle(1);
    pop_compare("after_corrupt");
    idle(2);
    expect_no_errors("after_corrupt");
  endtask

  task automatic test_pad();
    build_packet(9'h0A5, 1'b0);
    beats[18][63] = 1'b1;
    send_beats(19, -1, -1, 0);
    idle(4);
    expect_abort("pad", last_edge);
  endtask

  task automatic test_timeout();
    build_packet(9'h155, 1'b0);
    send_beats(11, -1, -1, 0);
    idle(10);
    checks++;
    if (decap_busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout busy during gap got=%b want=1", decap_busy);
    end
    checks++;
    if (err_q.size() !== 0) begin
      failures++;
      $display("FAIL timeout early error pulses=%0d want=0", err_q.size());
    end
    idle(250);
    expect_abort("timeout", last_edge + 256);
  endtask

  task automatic test_reset_mid();
    build_packet(9'h0A5, 1'b1);
    send_beats(10, -1, -1, 0);
    @(negedge clk);
    rst = 1'b1;
    data_recv_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (data_dfx_recv !== '0 || header_pkt_recv !== '0 || decap_valid !== 1'b0 ||
        decap_error !== 1'b0 || decap_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid outputs not zero hdr=%h v=%b e=%b b=%b", header_pkt_recv,
               decap_valid, decap_error, decap_busy);
    end
    last_data = '0;
    last_hdr  = '0;
    idle(3);
    expect_no_errors("reset_mid");
    build_packet(9'h0A5, 1'b1);
    send_beats(19, -1, -1, 0);
    push_expected();
    idle(1);
    pop_compare("after_reset");
    idle(2);
    expect_no_errors("after_reset");
  endtask

  task automatic test_exclusive();
    checks++;
    if (overlap !== 0) begin
      failures++;
      $display("FAIL exclusive valid&error cycles got=%0d want=0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_back_to_back();
    test_header_corrupt();
    test_pad();
    test_timeout();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
